// File: rtl/intc_priority_if.sv
// Core-side bus of the interrupt controller: intr/inta handshake plus the
// small memory-mapped register port driven from the MEM stage.
interface intc_priority_if;
   logic        intr;
   logic        inta;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        in_service;

   modport master (input intr, rdata, in_service, output inta, addr, we, wdata);
   modport slave  (output intr, rdata, in_service, input inta, addr, we, wdata);
endinterface

// File: rtl/intc_priority.sv
// Prioritised interrupt controller: synchronised sources, per-source pending,
// mask and edge/level config, one request at a time held in service until EOI.
module intc_priority #(
   parameter int            N_SRC   = 8,
   parameter int            ID_W    = 4,
   parameter logic [ID_W-1:0] SPUR_ID = 4'hF
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [N_SRC-1:0] irq_src,
   intc_priority_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

   state_t state, next;
   logic [N_SRC-1:0] s1, s2, s3;
   logic [N_SRC-1:0] pend, mask, edge_cfg;
   logic [N_SRC-1:0] pend_nxt, rise, clr, edge_chg, elig, elig_ack, win_oh, ack_clr;
   logic [ID_W-1:0]  win_id, vec_id;
   logic             vec_valid, ack, eoi, intr_d, intr_q;

   assign ack = bus.inta && (state == REQ);
   assign eoi = bus.we && (bus.addr == 2'd3) && (state == SERV);

   always_comb begin
      rise     = s2 & ~s3;
      clr      = (bus.we && bus.addr == 2'd0) ? (bus.wdata[N_SRC-1:0] & edge_cfg) : '0;
      edge_chg = (bus.we && bus.addr == 2'd2) ? (bus.wdata[N_SRC-1:0] ^ edge_cfg) : '0;
      elig     = pend & mask;
      // The acknowledge sees a same-cycle software clear, so a cleared winner reads spurious.
      elig_ack = pend & ~clr & mask;
      win_id   = '0;
      win_oh   = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (elig_ack[i]) begin
            win_id = ID_W'(i);
            win_oh = N_SRC'(1) << i;
         end
      end
      ack_clr  = (ack && |elig_ack) ? (win_oh & edge_cfg) : '0;
      // New edges win over any clear in the same cycle; level bits just track the line.
      pend_nxt = ((edge_cfg & (rise | (pend & ~clr & ~ack_clr))) | (~edge_cfg & s2)) & ~edge_chg;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         IDLE: if (|elig) next = REQ;
         REQ:  if (ack || !(|elig)) next = ack && |elig_ack ? SERV : IDLE;
         SERV: if (eoi) next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      intr_d         = (next == REQ);
      bus.in_service = (state == SERV);
      bus.intr       = intr_q;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1        <= '0;
         s2        <= '0;
         s3        <= '0;
         pend      <= '0;
         mask      <= '0;
         edge_cfg  <= '0;
         vec_valid <= 1'b0;
         vec_id    <= '0;
         intr_q    <= 1'b0;
      end else begin
         s1     <= irq_src;
         s2     <= s1;
         s3     <= s2;
         pend   <= pend_nxt;
         intr_q <= intr_d;
         if (bus.we && bus.addr == 2'd1) mask     <= bus.wdata[N_SRC-1:0];
         if (bus.we && bus.addr == 2'd2) edge_cfg <= bus.wdata[N_SRC-1:0];
         if (ack) begin
            vec_valid <= |elig_ack;
            vec_id    <= |elig_ack ? win_id : SPUR_ID;
         end else if (eoi) begin
            vec_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.rdata = '0;
      case (bus.addr)
         2'd0: bus.rdata = 32'(pend);
         2'd1: bus.rdata = 32'(mask);
         2'd2: bus.rdata = 32'(edge_cfg);
         default: bus.rdata = {vec_valid, {(31 - ID_W){1'b0}}, vec_id};
      endcase
   end
endmodule

// File: tb/tb_intc_priority.sv
// Directed bench for intc_priority: each task drives one scenario and checks
// hand-computed values for intr, in_service and the register file.
module tb_intc_priority;
   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] irq_src = '0;
   int         pass_cnt = 0;
   int         total = 0;
   logic [31:0] v;

   intc_priority_if bus();

   intc_priority #(.N_SRC(8), .ID_W(4), .SPUR_ID(4'hF)) dut (
      .clock(clock), .resetn(resetn), .irq_src(irq_src), .bus(bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus.addr = a;
      #1;
      d = bus.rdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.addr = a; bus.we = 1'b1; bus.wdata = d;
      tick();
      bus.we = 1'b0; bus.wdata = '0;
   endtask

   task automatic ack();
      bus.inta = 1'b1;
      tick();
      bus.inta = 1'b0;
   endtask

   // irq pulse sampled at the next edge, then n further edges
   task automatic pulse(input logic [7:0] m, input int n);
      irq_src = m;
      tick();
      irq_src = '0;
      ticks(n);
   endtask

   task automatic test_reset();
      bus.inta = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
      resetn = 1'b0;
      #23 resetn = 1'b1;
      tick();
      total++; if (bus.intr !== 1'b0) $display("FAIL reset_intr got %b want 0", bus.intr); else pass_cnt++;
      total++; if (bus.in_service !== 1'b0) $display("FAIL reset_insvc got %b want 0", bus.in_service); else pass_cnt++;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), v);
         total++; if (v !== 32'h0) $display("FAIL reset_reg%0d got %h want 0", a, v); else pass_cnt++;
      end
   endtask

   task automatic test_edge_basic();
      wr(2'd1, 32'hFF);
      wr(2'd2, 32'hFF);
      pulse(8'h20, 2);
      rd(2'd0, v);
      total++; if (v !== 32'h20) $display("FAIL edge_pend_e3 got %h want 20", v); else pass_cnt++;
      total++; if (bus.intr !== 1'b0) $display("FAIL edge_intr_e3 got %b want 0", bus.intr); else pass_cnt++;
      tick();
      total++; if (bus.intr !== 1'b1) $display("FAIL edge_intr_e4 got %b want 1", bus.intr); else pass_cnt++;
      ack();
      rd(2'd3, v);
      total++; if (v !== 32'h8000_0005) $display("FAIL edge_vec got %h want 80000005", v); else pass_cnt++;
      rd(2'd0, v);
      total++; if (v !== 32'h0) $display("FAIL edge_pend_ack got %h want 0", v); else pass_cnt++;
      total++; if (bus.in_service !== 1'b1) $display("FAIL edge_insvc got %b want 1", bus.in_service); else pass_cnt++;
      total++; if (bus.intr !== 1'b0) $display("FAIL edge_intr_serv got %b want 0", bus.intr); else pass_cnt++;
      wr(2'd3, 32'h0);
      rd(2'd3, v);
      total++; if (v !== 32'h0000_0005) $display("FAIL edge_vec_eoi got %h want 00000005", v); else pass_cnt++;
      tick();
      total++; if (bus.intr !== 1'b0) $display("FAIL edge_intr_eoi got %b want 0", bus.intr); else pass_cnt++;
      total++; if (bus.in_service !== 1'b0) $display("FAIL edge_insvc_eoi got %b want 0", bus.in_service); else pass_cnt++;
   endtask

   task automatic test_priority();
      pulse(8'h44, 3);
      total++; if (bus.intr !== 1'b1) $display("FAIL prio_intr got %b want 1", bus.intr); else pass_cnt++;
      ack();
      rd(2'd3, v);
      total++; if (v !== 32'h8000_0002) $display("FAIL prio_vec1 got %h want 80000002", v); else pass_cnt++;
      rd(2'd0, v);
      total++; if (v !== 32'h40) $display("FAIL prio_pend got %h want 40", v); else pass_cnt++;
      wr(2'd3, 32'h0);
      total++; if (bus.intr !== 1'b0) $display("FAIL prio_intr_eoi got %b want 0", bus.intr); else pass_cnt++;
      tick();
      total++; if (bus.intr !== 1'b1) $display("FAIL prio_rereq got %b want 1", bus.intr); else pass_cnt++;
      ack();
      rd(2'd3, v);
      total++; if (v !== 32'h8000_0006) $display("FAIL prio_vec2 got %h want 80000006", v); else pass_cnt++;
      wr(2'd3, 32'h0);
      tick();
      total++; if (bus.intr !== 1'b0) $display("FAIL prio_idle got %b want 0", bus.intr); else pass_cnt++;
   endtask

   task automatic test_level();
      wr(2'd2, 32'hF7);
      irq_src = 8'h08;
      ticks(4);
      total++; if (bus.intr !== 1'b1) $display("FAIL lvl_intr got %b want 1", bus.intr); else pass_cnt++;
      ack();
      rd(2'd3, v);
      total++; if (v !== 32'h8000_0003) $display("FAIL lvl_vec1 got %h want 80000003", v); else pass_cnt++;
      rd(2'd0, v);
      total++; if (v !== 32'h08) $display("FAIL lvl_pend_held got %h want 08", v); else pass_cnt++;
      wr(2'd3, 32'h0);
      tick();
      total++; if (bus.intr !== 1'b1) $display("FAIL lvl_rereq got %b want 1", bus.intr); else pass_cnt++;
      ack();
      rd(2'd3, v);
      total++; if (v !== 32'h8000_0003) $display("FAIL lvl_vec2 got %h want 80000003", v); else pass_cnt++;
      irq_src = '0;
      ticks(3);
      rd(2'd0, v);
      total++; if (v !== 32'h0) $display("FAIL lvl_pend_drop got %h want 0", v); else pass_cnt++;
      wr(2'd3, 32'h0);
      tick();
      total++; if (bus.intr !== 1'b0) $display("FAIL lvl_intr_final got %b want 0", bus.intr); else pass_cnt++;
      total++; if (bus.in_service !== 1'b0) $display("FAIL lvl_insvc got %b want 0", bus.in_service); else pass_cnt++;
   endtask

   task automatic test_mask();
      wr(2'd1, 32'h00);
      wr(2'd2, 32'hFF);
      pulse(8'h02, 3);
      rd(2'd0, v);
      total++; if (v !== 32'h02) $display("FAIL mask_pend got %h want 02", v); else pass_cnt++;
      total++; if (bus.intr !== 1'b0) $display("FAIL mask_intr got %b want 0", bus.intr); else pass_cnt++;
      wr(2'd1, 32'h02);
      tick();
      total++; if (bus.intr !== 1'b1) $display("FAIL mask_unmask got %b want 1", bus.intr); else pass_cnt++;
      ack();
      rd(2'd3, v);
      total++; if (v !== 32'h8000_0001) $display("FAIL mask_vec got %h want 80000001", v); else pass_cnt++;
      wr(2'd3, 32'h0);
      wr(2'd1, 32'hFF);
   endtask

   task automatic test_spurious();
      pulse(8'h10, 3);
      total++; if (bus.intr !== 1'b1) $display("FAIL spur_intr got %b want 1", bus.intr); else pass_cnt++;
      bus.addr = 2'd0; bus.we = 1'b1; bus.wdata = 32'h10; bus.inta = 1'b1;
      tick();
      bus.we = 1'b0; bus.wdata = '0; bus.inta = 1'b0;
      rd(2'd3, v);
      total++; if (v !== 32'h0000_000F) $display("FAIL spur_vec got %h want 0000000f", v); else pass_cnt++;
      total++; if (bus.intr !== 1'b0) $display("FAIL spur_intr_after got %b want 0", bus.intr); else pass_cnt++;
      total++; if (bus.in_service !== 1'b0) $display("FAIL spur_insvc got %b want 0", bus.in_service); else pass_cnt++;
      rd(2'd0, v);
      total++; if (v !== 32'h0) $display("FAIL spur_pend got %h want 0", v); else pass_cnt++;
      tick();
      total++; if (bus.intr !== 1'b0) $display("FAIL spur_idle got %b want 0", bus.intr); else pass_cnt++;
   endtask

   task automatic test_set_wins();
      pulse(8'h01, 1);
      bus.addr = 2'd0; bus.we = 1'b1; bus.wdata = 32'h01;
      tick();
      bus.we = 1'b0; bus.wdata = '0;
      rd(2'd0, v);
      total++; if (v !== 32'h01) $display("FAIL setwin_pend got %h want 01", v); else pass_cnt++;
      tick();
      total++; if (bus.intr !== 1'b1) $display("FAIL setwin_intr got %b want 1", bus.intr); else pass_cnt++;
      ack();
      rd(2'd3, v);
      total++; if (v !== 32'h8000_0000) $display("FAIL setwin_vec got %h want 80000000", v); else pass_cnt++;
      wr(2'd3, 32'h0);
   endtask

   task automatic test_reset_serv();
      pulse(8'h84, 3);
      ack();
      total++; if (bus.in_service !== 1'b1) $display("FAIL rst_insvc_pre got %b want 1", bus.in_service); else pass_cnt++;
      rd(2'd0, v);
      total++; if (v !== 32'h80) $display("FAIL rst_pend_pre got %h want 80", v); else pass_cnt++;
      #1 resetn = 1'b0;
      #1;
      total++; if (bus.intr !== 1'b0) $display("FAIL rst_intr got %b want 0", bus.intr); else pass_cnt++;
      total++; if (bus.in_service !== 1'b0) $display("FAIL rst_insvc got %b want 0", bus.in_service); else pass_cnt++;
      rd(2'd0, v);
      total++; if (v !== 32'h0) $display("FAIL rst_pend got %h want 0", v); else pass_cnt++;
      rd(2'd1, v);
      total++; if (v !== 32'h0) $display("FAIL rst_mask got %h want 0", v); else pass_cnt++;
      rd(2'd3, v);
      total++; if (v !== 32'h0) $display("FAIL rst_vec got %h want 0", v); else pass_cnt++;
      #10 resetn = 1'b1;
      ticks(2);
   endtask

   initial begin
      test_reset();
      test_edge_basic();
      test_priority();
      test_level();
      test_mask();
      test_spurious();
      test_set_wins();
      test_reset_serv();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/intc_priority.md
Name: intc_priority

Overview:
- Prioritised interrupt controller in front of the pipelined MIPS core's single intr/inta pair.
- Synchronises N_SRC external interrupt lines and keeps per-source pending, mask and edge/level configuration.
- Raises intr toward the core's control unit and captures the winning source ID when the core pulses inta.
- Holds that source in service until software writes EOI through a small memory-mapped register port driven from the MEM stage.

Parameters:
- N_SRC, 8, number of interrupt sources (2..16); source 0 has the highest priority.
- ID_W, 4, width of the source ID field; must satisfy 2**ID_W > N_SRC.
- SPUR_ID, 4'hF, ID reported when inta finds no eligible source.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- irq_src  in  N_SRC  raw asynchronous interrupt lines.
- intr  out  1  interrupt request to the core; registered.
- inta  in  1  one-cycle acknowledge pulse from the core.
- addr  in  2  register select: 0 PEND, 1 MASK, 2 EDGE, 3 VEC/EOI.
- we  in  1  register write strobe.
- wdata  in  32  write data.
- rdata  out  32  combinational read of the register selected by addr; unused bits read 0.
- in_service  out  1  a source is being serviced (state SERV).

Behaviour:
- Reset (asynchronous): all pending, mask, edge and synchroniser bits 0; state IDLE; intr=0; in_service=0; VEC={valid=0, id=0}.
- Synchroniser: two flops per source, then an edge-detect flop.
- Pending update: EDGE[i]=1 sets PEND[i] on a synchronised 0->1 and holds it until cleared. EDGE[i]=0 makes PEND[i] follow the synchronised level each cycle.
- Latency: a source rising before clock edge 1 sets PEND at edge 3 and drives intr=1 after edge 4.
- Eligible set: PEND & MASK. Winner = lowest eligible index.
- PEND register (addr 0): writing 1 clears edge-mode bits; writes to level-mode bits are ignored. If a new edge and a write-1-clear hit the same bit in the same cycle, the set wins.
- MASK (addr 1) and EDGE (addr 2): read/write, low N_SRC bits. Changing EDGE clears that bit's PEND.
- VEC (addr 3), read: bit 31 = valid, [ID_W-1:0] = latched id.
- EOI: any write to addr 3.
- FSM state IDLE: if eligible is non-empty, go to REQ.
- FSM state REQ: intr=1.
  - Eligible goes empty before inta: return to IDLE and drop intr.
  - inta with eligible non-empty: latch the winner into VEC with valid=1; clear its PEND if edge-mode; go to SERV.
  - inta with eligible empty in that cycle: VEC={0, SPUR_ID}; go to IDLE.
- FSM state SERV: intr=0, in_service=1. New pendings accumulate but are not requested. EOI returns to IDLE and clears VEC.valid. inta in SERV is ignored.
- inta in IDLE is ignored; VEC is unchanged.
- EOI in IDLE or REQ is ignored.
- No nesting: a higher-priority source arriving in SERV waits for EOI.
- Level source: if still asserted after EOI, it re-requests from IDLE on the next cycle.
- Masking the winning source during REQ drops intr next cycle if no other source is eligible.
- Reset asserted mid-service: immediate return to the reset state; pending interrupts are lost.

Test Plan:
- Reset, MASK=0xFF, EDGE=0xFF, pulse irq_src[5] for one cycle -> PEND=0x20 at edge 3, intr=1 after edge 4; inta -> VEC=0x8000_0005, PEND=0, in_service=1, intr=0; EOI -> intr stays 0, VEC.valid=0.
- Sources 6 and 2 rise in the same cycle, all unmasked -> inta returns id 2, PEND=0x40; EOI -> intr re-asserts the next cycle; inta returns id 6.
- Level source 3 (EDGE=0) held high through EOI -> re-request, second inta again id 3. Drop the line, then EOI -> intr stays 0.
- MASK=0x00 and source 1 pulses -> PEND=0x02, intr=0. Write MASK=0x02 -> intr=1 next cycle.
- State REQ on source 4 (edge); a write-1-clear of PEND bit 4 and inta occur in the same cycle -> VEC=0x0000_000F (spurious), state IDLE, intr=0.
- Same-cycle new edge on source 0 and write-1-clear of PEND bit 0 -> PEND bit 0 stays 1.
- Drop resetn while in SERV -> intr=0, in_service=0, PEND=0, MASK=0 immediately.
